decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised, registered decode stage placed between fetch and execute. Each accepted instruction word is decoded into the control bundle used by the ALU, the operand muxes, the PC mux, writeback and the CSR file. The result is held in a DEPTH-entry queue with valid/ready handshakes on both sides. It also adds RV32M decode, illegal-instruction detection and pipeline flush.

## Interface
- DEPTH, 2: number of queued decoded entries; legal values are 1 to 16.
- ENABLE_M, 0: when 1, decode RV32M (funct7 = 0000001 on OP); when 0, these encodings are illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch is presenting code and pc.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- code  in  32  instruction word.
- pc  in  32  instruction address.
- flush  in  1  discard all queued entries, for a redirect or trap.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  execute consumes the head this cycle.
- out_pc, out_code  out  32 each  stored pc and code.
- rs1_num, rs2_num, rd_num  out  5 each  register numbers.
- imm  out  32  immediate.
- alu_op_sel  out  `ALU_OP_WIDTH  ALU operation select.
- src_a_sel  out  `SEL_SRC_A_WIDTH  ALU operand A mux select.
- src_b_sel  out  `SEL_SRC_B_WIDTH  ALU operand B mux select.
- pc_sel  out  `SEL_PC_WIDTH  next-PC mux select.
- wb_reg  out  1  write rd.
- mdu_valid  out  1  the entry is an RV32M operation.
- mdu_op  out  3  RV32M funct3.
- csr_addr  out  12  CSR address; `CSR_ADDR_MCAUSE for ECALL, `CSR_ADDR_NONE for non-SYSTEM instructions.
- csr_op  out  3  SYSTEM funct3.
- csr_wb  out  1  CSR write enable.
- illegal  out  1  the entry is an undecodable instruction.

## Operation
- Decode is combinational on code/pc at enqueue. Only the decoded fields plus pc and code are stored.
- **Instruction types:**
  - I: LOAD, OP-IMM, MISC-MEM, JALR.
  - U: LUI, AUIPC.
  - R: OP.
  - S: STORE.
  - B: BRANCH.
  - J: JAL.
- **Immediates:** the standard RV32I immediate for each type; 0 for R-type and SYSTEM.
- **Register numbers:**
  - rs1_num is forced to 0 for U/J.
  - rs2_num is forced to 0 for I/U/J.
  - rd_num is forced to 0 for S/B.
- **ALU operation:**
  - OP/OP-IMM: the funct3 map. For funct3 = 101, funct7 0000000 gives SRL and funct7 0100000 gives SRA.
  - SLLI, SRLI and SRAI with imm[11:5] outside {0000000, 0100000} are illegal.
  - BRANCH: SEQ, SNE, SLT, SGE, SLTU, SGEU.
  - LOAD, STORE, LUI, AUIPC, JAL, JALR: ADD.
- **Operand and PC selects:**
  - JAL/JALR: src_a is PC, src_b is 4.
  - LUI: src_a is IMM, src_b is 0.
  - AUIPC: src_a is PC, src_b is IMM.
  - pc_sel: JAL for JAL, JALR for JALR, MTVEC for ECALL (0x00000073), MEPC for MRET (0x30200073), ADD4 otherwise.
- wb_reg is 1 for I/R/U/J types, for CSR instructions, and for RV32M operations.
- **RV32M** (ENABLE_M = 1, OP with funct7 0000001): mdu_valid = 1, mdu_op = funct3, alu_op_sel = `ALU_OP_NONE.
- **CSR write enable:** csr_wb = 1 for CSRRW, CSRRWI and ECALL; 0 otherwise.
- **Illegal instructions:** illegal = 1 for any of:
  - code[1:0] != 11;
  - an unknown opcode;
  - an unused funct3 on BRANCH, LOAD or STORE;
  - an unknown funct7 on OP;
  - any SYSTEM word other than ECALL, MRET or a CSR* instruction;
  - RV32M encodings when ENABLE_M = 0.
- **Illegal entries:** queued normally, with wb_reg = 0, csr_wb = 0, mdu_valid = 0, and pc_sel = MTVEC.
- **Queue:** a circular buffer with rd_ptr, wr_ptr and count.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Pointers wrap from DEPTH-1 to 0 and are not required to be powers of two.
  - Push and pop in the same cycle leave count unchanged.
  - in_ready does not look at out_ready, so a full queue refuses a push even when a pop happens in that cycle.
- **Flush:** count, rd_ptr and wr_ptr are cleared on the next edge. A push or pop presented in the flush cycle is ignored.

## Timing
- **Reset:** on an edge with rst = 1, count, rd_ptr, wr_ptr and all storage are cleared to 0.
  - Afterwards: out_valid = 0, in_ready = 1, and all data outputs read 0.
  - rst takes priority over flush and over any push or pop.
  - Reset in the middle of operation drops all entries.
- **Latency:**
  - An entry pushed at edge N appears on the outputs after edge N (cycle N+1) if the queue was empty.
  - Otherwise it appears after all older entries have been popped.
  - No combinational path from in_* to out_*.
- **Output stability:** outputs are driven from storage at rd_ptr. While out_valid = 1 and out_ready = 0, all outputs hold stable.
- **Throughput:** one instruction per cycle sustained when DEPTH >= 2 and out_ready = 1. With DEPTH = 1, one instruction every 2 cycles.

## Test plan
- **ADDI:** reset, then push 0x00500093 (addi x1,x0,5) with out_ready = 1.
  - Next cycle: out_valid = 1, rd_num = 1, rs1_num = 0, rs2_num = 0, imm = 5.
  - ALU_OP_ADD, src_a RS1, src_b IMM, wb_reg = 1, illegal = 0.
- **SRA:** push 0x4020D1B3 (sra x3,x1,x2).
  - alu_op_sel = ALU_OP_SRA, rs1_num = 1, rs2_num = 2, rd_num = 3, src_b RS2.
- **MUL:** push 0x027302B3 (mul x5,x6,x7).
  - ENABLE_M = 1: mdu_valid = 1, mdu_op = 0, illegal = 0.
  - ENABLE_M = 0: illegal = 1, wb_reg = 0, pc_sel = MTVEC.
- **Fill and drain:** DEPTH = 2, out_ready = 0, push three words on consecutive cycles.
  - The first two are accepted; in_ready = 0 from cycle 2, and the third is held.
  - Raise out_ready: entries emerge in order with pc values preserved, then the third is accepted.
- **Flush:** with 2 entries queued, assert flush together with in_valid = 1.
  - Next cycle: out_valid = 0, in_ready = 1, and the pushed word does not appear.
- **SYSTEM decode:**
  - 0x00000073 (ECALL): pc_sel = MTVEC, csr_addr = MCAUSE, csr_wb = 1.
  - 0x30200073 (MRET): pc_sel = MEPC, csr_wb = 0.
  - 0x00000000: illegal = 1.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: RV32I/RV32M decode stage feeding a DEPTH-entry valid/ready queue.
// Decoded control bundle is computed combinationally from code/pc and stored at enqueue;
// all outputs are driven from the storage entry at the read pointer.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH     4
`define ALU_OP_NONE      4'd0
`define ALU_OP_ADD       4'd1
`define ALU_OP_SUB       4'd2
`define ALU_OP_SLL       4'd3
`define ALU_OP_SLT       4'd4
`define ALU_OP_SLTU      4'd5
`define ALU_OP_XOR       4'd6
`define ALU_OP_SRL       4'd7
`define ALU_OP_SRA       4'd8
`define ALU_OP_OR        4'd9
`define ALU_OP_AND       4'd10
`define ALU_OP_SEQ       4'd11
`define ALU_OP_SNE       4'd12
`define ALU_OP_SGE       4'd13
`define ALU_OP_SGEU      4'd14
`endif
`ifndef SEL_SRC_A_WIDTH
`define SEL_SRC_A_WIDTH  2
`define SEL_SRC_A_RS1    2'd0
`define SEL_SRC_A_PC     2'd1
`define SEL_SRC_A_IMM    2'd2
`endif
`ifndef SEL_SRC_B_WIDTH
`define SEL_SRC_B_WIDTH  2
`define SEL_SRC_B_RS2    2'd0
`define SEL_SRC_B_IMM    2'd1
`define SEL_SRC_B_FOUR   2'd2
`define SEL_SRC_B_ZERO   2'd3
`endif
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH     3
`define SEL_PC_ADD4      3'd0
`define SEL_PC_JAL       3'd1
`define SEL_PC_JALR      3'd2
`define SEL_PC_MTVEC     3'd3
`define SEL_PC_MEPC      3'd4
`endif
`ifndef CSR_ADDR_MCAUSE
`define CSR_ADDR_MCAUSE  12'h342
`define CSR_ADDR_NONE    12'h000
`endif

module decode_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter bit          ENABLE_M = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  code,
   input  logic [31:0]                  pc,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_pc,
   output logic [31:0]                  out_code,
   output logic [4:0]                   rs1_num,
   output logic [4:0]                   rs2_num,
   output logic [4:0]                   rd_num,
   output logic [31:0]                  imm,
   output logic [`ALU_OP_WIDTH-1:0]     alu_op_sel,
   output logic [`SEL_SRC_A_WIDTH-1:0]  src_a_sel,
   output logic [`SEL_SRC_B_WIDTH-1:0]  src_b_sel,
   output logic [`SEL_PC_WIDTH-1:0]     pc_sel,
   output logic                         wb_reg,
   output logic                         mdu_valid,
   output logic [2:0]                   mdu_op,
   output logic [11:0]                  csr_addr,
   output logic [2:0]                   csr_op,
   output logic                         csr_wb,
   output logic                         illegal
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic [31:0]                  pc;
      logic [31:0]                  code;
      logic [4:0]                   rs1;
      logic [4:0]                   rs2;
      logic [4:0]                   rd;
      logic [31:0]                  imm;
      logic [`ALU_OP_WIDTH-1:0]     alu;
      logic [`SEL_SRC_A_WIDTH-1:0]  sa;
      logic [`SEL_SRC_B_WIDTH-1:0]  sb;
      logic [`SEL_PC_WIDTH-1:0]     psel;
      logic                         wb;
      logic                         mv;
      logic [2:0]                   mop;
      logic [11:0]                  caddr;
      logic [2:0]                   cop;
      logic                         cwb;
      logic                         ill;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;

   entry_t          w_dec;
   entry_t          w_head;
   logic            w_push;
   logic            w_pop;
   logic [PW-1:0]   w_rd_next;
   logic [PW-1:0]   w_wr_next;
   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;

   // funct3 -> ALU operation for OP / OP-IMM (shift variants resolved by caller)
   function automatic logic [`ALU_OP_WIDTH-1:0] alu_map(input logic [2:0] f3);
      case (f3)
         3'b000:  alu_map = `ALU_OP_ADD;
         3'b001:  alu_map = `ALU_OP_SLL;
         3'b010:  alu_map = `ALU_OP_SLT;
         3'b011:  alu_map = `ALU_OP_SLTU;
         3'b100:  alu_map = `ALU_OP_XOR;
         3'b101:  alu_map = `ALU_OP_SRL;
         3'b110:  alu_map = `ALU_OP_OR;
         default: alu_map = `ALU_OP_AND;
      endcase
   endfunction

   assign w_opc = code[6:0];
   assign w_f3  = code[14:12];
   assign w_f7  = code[31:25];

   // Combinational decode of the presented instruction word into the stored bundle
   always_comb begin
      w_dec       = '0;
      w_dec.pc    = pc;
      w_dec.code  = code;
      w_dec.rs1   = code[19:15];
      w_dec.rs2   = code[24:20];
      w_dec.rd    = code[11:7];
      w_dec.alu   = `ALU_OP_NONE;
      w_dec.sa    = `SEL_SRC_A_RS1;
      w_dec.sb    = `SEL_SRC_B_RS2;
      w_dec.psel  = `SEL_PC_ADD4;
      w_dec.caddr = `CSR_ADDR_NONE;
      case (w_opc)
         OPC_LOAD: begin
            w_dec.imm = {{20{code[31]}}, code[31:20]};
            w_dec.rs2 = '0;
            w_dec.alu = `ALU_OP_ADD;
            w_dec.sb  = `SEL_SRC_B_IMM;
            w_dec.wb  = 1'b1;
            w_dec.ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         OPC_MISC_MEM: begin
            w_dec.imm = {{20{code[31]}}, code[31:20]};
            w_dec.rs2 = '0;
            w_dec.sb  = `SEL_SRC_B_IMM;
            w_dec.wb  = 1'b1;
         end
         OPC_OP_IMM: begin
            w_dec.imm = {{20{code[31]}}, code[31:20]};
            w_dec.rs2 = '0;
            w_dec.sb  = `SEL_SRC_B_IMM;
            w_dec.wb  = 1'b1;
            w_dec.alu = alu_map(w_f3);
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               if (w_f7 == 7'b0100000 && w_f3 == 3'b101)
                  w_dec.alu = `ALU_OP_SRA;
               else if (w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                  w_dec.ill = 1'b1;
            end
         end
         OPC_AUIPC: begin
            w_dec.imm = {code[31:12], 12'b0};
            w_dec.rs1 = '0;
            w_dec.rs2 = '0;
            w_dec.alu = `ALU_OP_ADD;
            w_dec.sa  = `SEL_SRC_A_PC;
            w_dec.sb  = `SEL_SRC_B_IMM;
            w_dec.wb  = 1'b1;
         end
         OPC_STORE: begin
            w_dec.imm = {{20{code[31]}}, code[31:25], code[11:7]};
            w_dec.rd  = '0;
            w_dec.alu = `ALU_OP_ADD;
            w_dec.sb  = `SEL_SRC_B_IMM;
            w_dec.ill = (w_f3 > 3'b010);
         end
         OPC_OP: begin
            w_dec.wb = 1'b1;
            if (w_f7 == 7'b0000000) begin
               w_dec.alu = alu_map(w_f3);
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
               w_dec.alu = `ALU_OP_SUB;
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
               w_dec.alu = `ALU_OP_SRA;
            end else if (w_f7 == 7'b0000001 && ENABLE_M) begin
               w_dec.mv  = 1'b1;
               w_dec.mop = w_f3;
            end else begin
               w_dec.ill = 1'b1;
            end
         end
         OPC_LUI: begin
            w_dec.imm = {code[31:12], 12'b0};
            w_dec.rs1 = '0;
            w_dec.rs2 = '0;
            w_dec.alu = `ALU_OP_ADD;
            w_dec.sa  = `SEL_SRC_A_IMM;
            w_dec.sb  = `SEL_SRC_B_ZERO;
            w_dec.wb  = 1'b1;
         end
         OPC_BRANCH: begin
            w_dec.imm = {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
            w_dec.rd  = '0;
            case (w_f3)
               3'b000:  w_dec.alu = `ALU_OP_SEQ;
               3'b001:  w_dec.alu = `ALU_OP_SNE;
               3'b100:  w_dec.alu = `ALU_OP_SLT;
               3'b101:  w_dec.alu = `ALU_OP_SGE;
               3'b110:  w_dec.alu = `ALU_OP_SLTU;
               3'b111:  w_dec.alu = `ALU_OP_SGEU;
               default: w_dec.ill = 1'b1;
            endcase
         end
         OPC_JALR: begin
            w_dec.imm  = {{20{code[31]}}, code[31:20]};
            w_dec.rs2  = '0;
            w_dec.alu  = `ALU_OP_ADD;
            w_dec.sa   = `SEL_SRC_A_PC;
            w_dec.sb   = `SEL_SRC_B_FOUR;
            w_dec.psel = `SEL_PC_JALR;
            w_dec.wb   = 1'b1;
         end
         OPC_JAL: begin
            w_dec.imm  = {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
            w_dec.rs1  = '0;
            w_dec.rs2  = '0;
            w_dec.alu  = `ALU_OP_ADD;
            w_dec.sa   = `SEL_SRC_A_PC;
            w_dec.sb   = `SEL_SRC_B_FOUR;
            w_dec.psel = `SEL_PC_JAL;
            w_dec.wb   = 1'b1;
         end
         OPC_SYSTEM: begin
            w_dec.caddr = code[31:20];
            w_dec.cop   = w_f3;
            if (w_f3 == 3'b000) begin
               if (code == 32'h0000_0073) begin
                  w_dec.psel  = `SEL_PC_MTVEC;
                  w_dec.caddr = `CSR_ADDR_MCAUSE;
                  w_dec.cwb   = 1'b1;
               end else if (code == 32'h3020_0073) begin
                  w_dec.psel = `SEL_PC_MEPC;
               end else begin
                  w_dec.ill = 1'b1;
               end
            end else if (w_f3 == 3'b100) begin
               w_dec.ill = 1'b1;
            end else begin
               w_dec.wb  = 1'b1;
               w_dec.cwb = (w_f3 == 3'b001) || (w_f3 == 3'b101);
            end
         end
         default: w_dec.ill = 1'b1;
      endcase
      if (code[1:0] != 2'b11)
         w_dec.ill = 1'b1;
      // illegal entries still queue, but must not write state and must trap
      if (w_dec.ill) begin
         w_dec.wb   = 1'b0;
         w_dec.cwb  = 1'b0;
         w_dec.mv   = 1'b0;
         w_dec.psel = `SEL_PC_MTVEC;
      end
   end

   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_rd_next = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
   assign w_wr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

   // Circular-buffer storage, pointers and occupancy; reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
            r_wr_ptr        <= w_wr_next;
         end
         if (w_pop)
            r_rd_ptr <= w_rd_next;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign out_pc     = w_head.pc;
   assign out_code   = w_head.code;
   assign rs1_num    = w_head.rs1;
   assign rs2_num    = w_head.rs2;
   assign rd_num     = w_head.rd;
   assign imm        = w_head.imm;
   assign alu_op_sel = w_head.alu;
   assign src_a_sel  = w_head.sa;
   assign src_b_sel  = w_head.sb;
   assign pc_sel     = w_head.psel;
   assign wb_reg     = w_head.wb;
   assign mdu_valid  = w_head.mv;
   assign mdu_op     = w_head.mop;
   assign csr_addr   = w_head.caddr;
   assign csr_op     = w_head.cop;
   assign csr_wb     = w_head.cwb;
   assign illegal    = w_head.ill;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: two instances (ENABLE_M = 1 and 0) share stimulus;
// expected bundles are queued on acceptance and popped by monitors at each output handshake.
`timescale 1ns/1ps

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH     4
`define ALU_OP_NONE      4'd0
`define ALU_OP_ADD       4'd1
`define ALU_OP_SUB       4'd2
`define ALU_OP_SLL       4'd3
`define ALU_OP_SLT       4'd4
`define ALU_OP_SLTU      4'd5
`define ALU_OP_XOR       4'd6
`define ALU_OP_SRL       4'd7
`define ALU_OP_SRA       4'd8
`define ALU_OP_OR        4'd9
`define ALU_OP_AND       4'd10
`define ALU_OP_SEQ       4'd11
`define ALU_OP_SNE       4'd12
`define ALU_OP_SGE       4'd13
`define ALU_OP_SGEU      4'd14
`endif
`ifndef SEL_SRC_A_WIDTH
`define SEL_SRC_A_WIDTH  2
`define SEL_SRC_A_RS1    2'd0
`define SEL_SRC_A_PC     2'd1
`define SEL_SRC_A_IMM    2'd2
`endif
`ifndef SEL_SRC_B_WIDTH
`define SEL_SRC_B_WIDTH  2
`define SEL_SRC_B_RS2    2'd0
`define SEL_SRC_B_IMM    2'd1
`define SEL_SRC_B_FOUR   2'd2
`define SEL_SRC_B_ZERO   2'd3
`endif
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH     3
`define SEL_PC_ADD4      3'd0
`define SEL_PC_JAL       3'd1
`define SEL_PC_JALR      3'd2
`define SEL_PC_MTVEC     3'd3
`define SEL_PC_MEPC      3'd4
`endif
`ifndef CSR_ADDR_MCAUSE
`define CSR_ADDR_MCAUSE  12'h342
`define CSR_ADDR_NONE    12'h000
`endif

module tb_decode_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] code;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [2:0]  psel;
      logic        wb;
      logic        mv;
      logic [2:0]  mop;
      logic [11:0] caddr;
      logic [2:0]  cop;
      logic        cwb;
      logic        ill;
      logic        m;
   } exp_t;

   logic clk = 1'b0;
   logic rst, in_valid, flush, out_ready;
   logic [31:0] code, pc;

   logic in_ready, out_valid, wb_reg, mdu_valid, csr_wb, illegal;
   logic [31:0] out_pc, out_code, imm;
   logic [4:0] rs1_num, rs2_num, rd_num;
   logic [3:0] alu_op_sel;
   logic [1:0] src_a_sel, src_b_sel;
   logic [2:0] pc_sel, mdu_op, csr_op;
   logic [11:0] csr_addr;

   logic z_in_ready, z_out_valid, z_wb_reg, z_mdu_valid, z_csr_wb, z_illegal;
   logic [31:0] z_out_pc, z_out_code, z_imm;
   logic [4:0] z_rs1_num, z_rs2_num, z_rd_num;
   logic [3:0] z_alu_op_sel;
   logic [1:0] z_src_a_sel, z_src_b_sel;
   logic [2:0] z_pc_sel, z_mdu_op, z_csr_op;
   logic [11:0] z_csr_addr;

   int total = 0;
   int bad   = 0;
   exp_t exp_q[$];
   exp_t exp0_q[$];
   exp_t vec[13];

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(2), .ENABLE_M(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code), .pc(pc),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_code(out_code), .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num), .imm(imm),
      .alu_op_sel(alu_op_sel), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .pc_sel(pc_sel),
      .wb_reg(wb_reg), .mdu_valid(mdu_valid), .mdu_op(mdu_op), .csr_addr(csr_addr),
      .csr_op(csr_op), .csr_wb(csr_wb), .illegal(illegal));

   decode_queue #(.DEPTH(2), .ENABLE_M(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .code(code), .pc(pc),
      .flush(flush), .out_valid(z_out_valid), .out_ready(out_ready), .out_pc(z_out_pc),
      .out_code(z_out_code), .rs1_num(z_rs1_num), .rs2_num(z_rs2_num), .rd_num(z_rd_num),
      .imm(z_imm), .alu_op_sel(z_alu_op_sel), .src_a_sel(z_src_a_sel),
      .src_b_sel(z_src_b_sel), .pc_sel(z_pc_sel), .wb_reg(z_wb_reg), .mdu_valid(z_mdu_valid),
      .mdu_op(z_mdu_op), .csr_addr(z_csr_addr), .csr_op(z_csr_op), .csr_wb(z_csr_wb),
      .illegal(z_illegal));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // fields that must hold for every entry; the rest only matter for legal entries
   task automatic cmp(input string who, input exp_t a, input exp_t e);
      chk({who, ".pc"}, a.pc, e.pc);
      chk({who, ".code"}, a.code, e.code);
      chk({who, ".illegal"}, {31'd0, a.ill}, {31'd0, e.ill});
      chk({who, ".wb_reg"}, {31'd0, a.wb}, {31'd0, e.wb});
      chk({who, ".csr_wb"}, {31'd0, a.cwb}, {31'd0, e.cwb});
      chk({who, ".mdu_valid"}, {31'd0, a.mv}, {31'd0, e.mv});
      chk({who, ".pc_sel"}, {29'd0, a.psel}, {29'd0, e.psel});
      if (!e.ill) begin
         chk({who, ".rs1"}, {27'd0, a.rs1}, {27'd0, e.rs1});
         chk({who, ".rs2"}, {27'd0, a.rs2}, {27'd0, e.rs2});
         chk({who, ".rd"}, {27'd0, a.rd}, {27'd0, e.rd});
         chk({who, ".imm"}, a.imm, e.imm);
         chk({who, ".alu"}, {28'd0, a.alu}, {28'd0, e.alu});
         chk({who, ".src_a"}, {30'd0, a.sa}, {30'd0, e.sa});
         chk({who, ".src_b"}, {30'd0, a.sb}, {30'd0, e.sb});
         chk({who, ".mdu_op"}, {29'd0, a.mop}, {29'd0, e.mop});
         chk({who, ".csr_addr"}, {20'd0, a.caddr}, {20'd0, e.caddr});
         chk({who, ".csr_op"}, {29'd0, a.cop}, {29'd0, e.cop});
      end
   endtask

   function automatic exp_t mk(input logic [31:0] c, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [31:0] im, input logic [3:0] alu,
                               input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ps,
                               input logic wb, input logic mv, input logic [11:0] ca,
                               input logic [2:0] co, input logic cw, input logic il,
                               input logic m);
      exp_t e;
      e.pc = 32'h0; e.code = c; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = im;
      e.alu = alu; e.sa = sa; e.sb = sb; e.psel = ps; e.wb = wb; e.mv = mv; e.mop = 3'd0;
      e.caddr = ca; e.cop = co; e.cwb = cw; e.ill = il; e.m = m;
      return e;
   endfunction

   // the ENABLE_M = 0 instance sees RV32M words as illegal traps
   function automatic exp_t no_m(input exp_t e);
      exp_t r = e;
      if (e.m) begin
         r.ill = 1'b1; r.wb = 1'b0; r.mv = 1'b0; r.cwb = 1'b0; r.psel = `SEL_PC_MTVEC;
      end
      return r;
   endfunction

   // Monitor for the ENABLE_M = 1 instance
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t a;
         a.pc = out_pc; a.code = out_code; a.rs1 = rs1_num; a.rs2 = rs2_num; a.rd = rd_num;
         a.imm = imm; a.alu = alu_op_sel; a.sa = src_a_sel; a.sb = src_b_sel; a.psel = pc_sel;
         a.wb = wb_reg; a.mv = mdu_valid; a.mop = mdu_op; a.caddr = csr_addr; a.cop = csr_op;
         a.cwb = csr_wb; a.ill = illegal; a.m = 1'b0;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL m1_unexpected_output actual pc=%h required no output", out_pc);
         end else begin
            cmp("m1", a, exp_q.pop_front());
         end
      end
   end

   // Monitor for the ENABLE_M = 0 instance
   always @(negedge clk) begin
      if (!rst && z_out_valid && out_ready) begin
         exp_t a;
         a.pc = z_out_pc; a.code = z_out_code; a.rs1 = z_rs1_num; a.rs2 = z_rs2_num;
         a.rd = z_rd_num; a.imm = z_imm; a.alu = z_alu_op_sel; a.sa = z_src_a_sel;
         a.sb = z_src_b_sel; a.psel = z_pc_sel; a.wb = z_wb_reg; a.mv = z_mdu_valid;
         a.mop = z_mdu_op; a.caddr = z_csr_addr; a.cop = z_csr_op; a.cwb = z_csr_wb;
         a.ill = z_illegal; a.m = 1'b0;
         if (exp0_q.size() == 0) begin
            total++; bad++;
            $display("FAIL m0_unexpected_output actual pc=%h required no output", z_out_pc);
         end else begin
            cmp("m0", a, no_m(exp0_q.pop_front()));
         end
      end
   end

   task automatic send(input exp_t e, input logic [31:0] p);
      bit done = 0;
      e.pc = p;
      code = e.code; pc = p; in_valid = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (in_ready && !rst && !flush) begin
            exp_q.push_back(e);
            exp0_q.push_back(e);
            @(posedge clk); #1;
            done = 1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         total++; bad++;
         $display("FAIL send_timeout actual=not_accepted required=accepted pc=%h", p);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain_m1", exp_q.size(), 0);
      chk("drain_m0", exp0_q.size(), 0);
   endtask

   initial begin
      vec[0]  = mk(32'h00500093, 5'd0, 5'd0, 5'd1, 32'd5, `ALU_OP_ADD, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[1]  = mk(32'h4020D1B3, 5'd1, 5'd2, 5'd3, 32'd0, `ALU_OP_SRA, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_ADD4, 1, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[2]  = mk(32'h027302B3, 5'd6, 5'd7, 5'd5, 32'd0, `ALU_OP_NONE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_ADD4, 1, 1, `CSR_ADDR_NONE, 3'd0, 0, 0, 1);
      vec[3]  = mk(32'h00000073, 5'd0, 5'd0, 5'd0, 32'd0, `ALU_OP_NONE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_MTVEC, 0, 0, `CSR_ADDR_MCAUSE, 3'd0, 1, 0, 0);
      vec[4]  = mk(32'h30200073, 5'd0, 5'd2, 5'd0, 32'd0, `ALU_OP_NONE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_MEPC, 0, 0, 12'h302, 3'd0, 0, 0, 0);
      vec[5]  = mk(32'h00000000, 5'd0, 5'd0, 5'd0, 32'd0, `ALU_OP_NONE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_MTVEC, 0, 0, `CSR_ADDR_NONE, 3'd0, 0, 1, 0);
      vec[6]  = mk(32'h123450B7, 5'd0, 5'd0, 5'd1, 32'h12345000, `ALU_OP_ADD, `SEL_SRC_A_IMM,
                   `SEL_SRC_B_ZERO, `SEL_PC_ADD4, 1, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[7]  = mk(32'h008000EF, 5'd0, 5'd0, 5'd1, 32'd8, `ALU_OP_ADD, `SEL_SRC_A_PC,
                   `SEL_SRC_B_FOUR, `SEL_PC_JAL, 1, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[8]  = mk(32'hFE209EE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, `ALU_OP_SNE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_ADD4, 0, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[9]  = mk(32'h0020A423, 5'd1, 5'd2, 5'd0, 32'd8, `ALU_OP_ADD, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_IMM, `SEL_PC_ADD4, 0, 0, `CSR_ADDR_NONE, 3'd0, 0, 0, 0);
      vec[10] = mk(32'h300312F3, 5'd6, 5'd0, 5'd5, 32'd0, `ALU_OP_NONE, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_RS2, `SEL_PC_ADD4, 1, 0, 12'h300, 3'd1, 1, 0, 0);
      vec[11] = mk(32'h02009093, 5'd1, 5'd0, 5'd1, 32'd32, `ALU_OP_SLL, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_IMM, `SEL_PC_MTVEC, 0, 0, `CSR_ADDR_NONE, 3'd0, 0, 1, 0);
      vec[12] = mk(32'h0000B083, 5'd1, 5'd0, 5'd1, 32'd0, `ALU_OP_ADD, `SEL_SRC_A_RS1,
                   `SEL_SRC_B_IMM, `SEL_PC_MTVEC, 0, 0, `CSR_ADDR_NONE, 3'd0, 0, 1, 0);

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      code = 32'h0; pc = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_code", out_code, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_wb_reg", {31'd0, wb_reg}, 32'd0);
      @(posedge clk); #1;

      // streaming decode of every vector back to back
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) send(vec[i], 32'h1000 + 32'(i) * 4);
      drain();

      // fill to DEPTH with the consumer stalled, then release
      out_ready = 1'b0;
      send(vec[0], 32'h2000);
      send(vec[1], 32'h2004);
      fork
         send(vec[6], 32'h2008);
         begin
            @(negedge clk);
            chk("full_in_ready", {31'd0, in_ready}, 32'd0);
            chk("full_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc_a", out_pc, 32'h2000);
            @(negedge clk);
            chk("hold_pc_b", out_pc, 32'h2000);
            chk("hold_rd", {27'd0, rd_num}, 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // flush with a simultaneous push: both queued and pushed words vanish
      out_ready = 1'b0;
      send(vec[3], 32'h3000);
      send(vec[4], 32'h3004);
      code = vec[0].code; pc = 32'h3008; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      exp_q.delete(); exp0_q.delete();
      @(negedge clk);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      send(vec[8], 32'h3010);
      drain();

      // reset in mid-operation drops queued entries
      out_ready = 1'b0;
      send(vec[7], 32'h4000);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete(); exp0_q.delete();
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_pc", out_pc, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      send(vec[10], 32'h4010);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
